// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: special digit codes,
// the dark segment pattern and the active-low hex glyph table.
package seg_pkg;

  localparam logic [4:0] CODE_BLANK  = 5'd16;
  localparam logic [4:0] CODE_DASH   = 5'd17;

  localparam logic [7:0] SEG_OFF     = 8'hFF;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  // Active-low g..a patterns for 0-9, A, b, C, d, E, F; entry [0] is the rightmost field.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational 5-bit digit code to active-low segment decoder.
// Codes 0..15 are hex glyphs, 17 is a dash, everything else is blank.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_BLANK;
    case (i_code)
      CODE_BLANK: o_seg = GLYPH_BLANK;
      CODE_DASH:  o_seg = GLYPH_DASH;
      default:    o_seg = i_code[4] ? GLYPH_BLANK : HEX_GLYPHS[i_code[3:0]];
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver with per-digit dp/blank/blink,
// PWM brightness and a registered frame tick.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned SCAN_DIV    = 5000,
  parameter int unsigned PWM_BITS    = 4,
  parameter int unsigned BLINK_SCANS = 256
) (
  input  logic                    clk100MHZ,
  input  logic                    rst,
  input  logic                    power,
  input  logic [5*N_DIGITS-1:0]   dig,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [7:0]              SEG,
  output logic [N_DIGITS-1:0]     AN,
  output logic                    frame_tick
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FRAME_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(BLINK_SCANS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);

  logic [PRESC_W-1:0]  r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic                r_blink_phase;
  logic                r_frame_tick;
  logic [N_DIGITS-1:0] r_an;
  logic [7:0]          r_seg;

  logic                w_slot_tick;
  logic                w_pwm_on;
  logic                w_visible;
  logic [4:0]          w_code;
  logic                w_dp;
  logic                w_blank;
  logic                w_blink;
  logic [6:0]          w_glyph;

  assign w_slot_tick = (r_presc == PRESC_LAST);
  assign w_pwm_on    = (brightness == '1) || (r_pwm_cnt < brightness);

  // Per-digit fields for the currently scanned index.
  always_comb begin
    w_code  = '0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_blink = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_code  = dig[5*i +: 5];
        w_dp    = dp_mask[i];
        w_blank = blank_mask[i];
        w_blink = blink_mask[i];
      end
    end
  end

  assign w_visible = power && w_pwm_on && !w_blank && !(w_blink && r_blink_phase);

  seg_glyph_dec u_glyph_dec (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

  always_ff @(posedge clk100MHZ) begin
    if (rst) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_pwm_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_an          <= '1;
      r_seg         <= SEG_OFF;
    end else begin
      r_presc   <= w_slot_tick ? '0 : r_presc + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_slot_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      // Lands in the first cycle of digit 0, alongside the index wrap.
      r_frame_tick <= w_slot_tick && (r_idx == IDX_LAST);
      if (r_frame_tick) begin
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
      if (w_visible) begin
        r_an  <= ~(AN_ONE << r_idx);
        r_seg <= {~w_dp, w_glyph};
      end else begin
        r_an  <= '1;
        r_seg <= SEG_OFF;
      end
    end
  end

  assign AN         = r_an;
  assign SEG        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule
